// File: rtl/ex_mem_pipe_reg_pkg.sv
// EX/MEM pipeline register: shared widths, control-bit layout and payload offsets.
// The payload is a flat vector: {alu_result, store_data, reg_rd, ctrl}, with ctrl in the LSBs.
package ex_mem_pipe_reg_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int CTRL_W         = 6;

    // Bit offsets of the control fields inside the payload
    localparam int OFS_FLAG_BEQ   = 0;
    localparam int OFS_BEQ_INSTR  = 1;
    localparam int OFS_MEM_WRITE  = 2;
    localparam int OFS_MEM_READ   = 3;
    localparam int OFS_REG_WRITE  = 4;
    localparam int OFS_MEM_TO_REG = 5;
    localparam int OFS_REG_RD     = CTRL_W;

    // Field order must match the OFS_* control offsets above (MSB first)
    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic beq_instruction;
        logic flag_beq;
    } ctrl_t;

    function automatic int payload_w(input int data_w, input int reg_addr_w);
        return 2 * data_w + reg_addr_w + CTRL_W;
    endfunction

    function automatic int ofs_store(input int reg_addr_w);
        return CTRL_W + reg_addr_w;
    endfunction

    function automatic int ofs_alu(input int data_w, input int reg_addr_w);
        return CTRL_W + reg_addr_w + data_w;
    endfunction

endpackage

// File: rtl/pipe_stage_slice.sv
// One retiming slice: W-bit register captured on the falling clock edge.
// Latency 1 falling edge; hold freezes the slice, bubble loads zero and beats hold.
// Async active-high reset clears the slice without a clock edge.
module pipe_stage_slice #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with DEPTH retiming slices, valid tracking and stall/flush counters.
// Latency DEPTH falling edges from inputs to outputs.
// stall holds every slice; flush kills every slice and wins over stall.
module ex_mem_pipe_reg
    import ex_mem_pipe_reg_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int DEPTH      = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  cnt_clear,
    input  logic                  valid_in,
    input  logic                  mem_to_reg_in,
    input  logic                  reg_write_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  beq_instruction_in,
    input  logic [DATA_W-1:0]     alu_result_in,
    input  logic [DATA_W-1:0]     store_data_in,
    input  logic [REG_ADDR_W-1:0] reg_rd_in,
    input  logic                  flag_beq_in,
    output logic                  mem_to_reg_out,
    output logic                  reg_write_out,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic                  beq_instruction_out,
    output logic [DATA_W-1:0]     alu_result_out,
    output logic [DATA_W-1:0]     store_data_out,
    output logic [REG_ADDR_W-1:0] reg_rd_out,
    output logic                  flag_beq_out,
    output logic                  valid_out,
    output logic                  branch_taken_out,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int PAYLOAD_W = payload_w(DATA_W, REG_ADDR_W);
    localparam int SLICE_W   = PAYLOAD_W + 1;
    localparam int OFS_SD    = ofs_store(REG_ADDR_W);
    localparam int OFS_ALU   = ofs_alu(DATA_W, REG_ADDR_W);

    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
        $error("ex_mem_pipe_reg: DEPTH must be in the range 1..4");
    end

    ctrl_t              ctrl_in;
    logic [SLICE_W-1:0] chain [0:DEPTH];
    logic [SLICE_W-1:0] last;

    assign ctrl_in = '{
        mem_to_reg:      mem_to_reg_in,
        reg_write:       reg_write_in,
        mem_read:        mem_read_in,
        mem_write:       mem_write_in,
        beq_instruction: beq_instruction_in,
        flag_beq:        flag_beq_in
    };

    // A bubble enters as all-zero so data fields never carry stale or X values
    assign chain[0] = valid_in ? {1'b1, alu_result_in, store_data_in, reg_rd_in, ctrl_in}
                               : '0;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slice
        pipe_stage_slice #(
            .W (SLICE_W)
        ) u_slice (
            .clock  (clock),
            .reset  (reset),
            .hold   (stall),
            .bubble (flush),
            .d      (chain[k]),
            .q      (chain[k+1])
        );
    end

    assign last = chain[DEPTH];

    assign valid_out           = last[PAYLOAD_W];
    assign alu_result_out      = last[OFS_ALU +: DATA_W];
    assign store_data_out      = last[OFS_SD +: DATA_W];
    assign reg_rd_out          = last[OFS_REG_RD +: REG_ADDR_W];
    assign mem_to_reg_out      = last[OFS_MEM_TO_REG];
    assign reg_write_out       = last[OFS_REG_WRITE];
    assign mem_read_out        = last[OFS_MEM_READ];
    assign mem_write_out       = last[OFS_MEM_WRITE];
    assign beq_instruction_out = last[OFS_BEQ_INSTR];
    assign flag_beq_out        = last[OFS_FLAG_BEQ];

    assign branch_taken_out = valid_out & beq_instruction_out & flag_beq_out;

    // Event counters saturate at all-ones; cnt_clear wins over any increment
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else if (cnt_clear) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall && !flush && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule
